// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_unit
// Brief   : Prefetching instruction fetch unit with address-tagged FIFO,
//           jump redirect (flush + refetch) and sticky halt.
// Rev     : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic [31:0]           ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jmp_inst,
  input  logic [ADDR_WIDTH-1:0] jmp_address,
  input  logic                  hlt_inst,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  localparam int                    c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                    c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]      c_depth   = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0]    c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);
  localparam logic [ADDR_WIDTH-1:0] c_pc_one  = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                r_state;
  logic [31:0]           r_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_tag  [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;

  logic                  w_run;
  logic                  w_flush;
  logic                  w_issue;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic [c_cnt_w:0]      w_occupancy;

  assign w_run       = (r_state == ST_RUN);
  assign w_flush     = w_run & (jmp_inst | hlt_inst);
  // Reservation counts the in-flight word; a same-cycle pop does not free space.
  assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue     = ~reset & w_run & ~jmp_inst & ~hlt_inst & (w_occupancy < c_depth);
  assign w_valid     = w_run & (r_count != '0);
  assign w_pop       = w_valid & ir_ready & ~w_flush;
  assign w_push      = r_inflight & ~w_flush;

  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? r_fetch_pc : '0;
  assign ir_valid  = w_valid;
  assign ir        = w_valid ? r_data[r_rd_ptr] : '0;
  assign ir_pc     = w_valid ? r_tag[r_rd_ptr]  : '0;
  assign halted    = (r_state == ST_HALT);
  assign fetch_pc  = r_fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fetch_pc    <= RESET_PC;
    end else begin
      // Any issue is suppressed on jump/halt, so the in-flight slot clears itself.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + c_pc_one;
      end else if (w_run & jmp_inst & ~hlt_inst) begin
        r_fetch_pc <= jmp_address;
      end

      if (w_run & hlt_inst) begin
        r_state <= ST_HALT;
      end

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (~reset & w_push) begin
      r_data[r_wr_ptr] <= mem_rd_data;
      r_tag[r_wr_ptr]  <= r_inflight_pc;
    end
  end

endmodule
`default_nettype wire
